// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl: multi-cycle multiply/divide sequencer for the E stage.
//   Owns HI/LO, counts out a fixed latency per operation and raises the
//   D-stage stall while an MD-class instruction would observe a pending op.
// Ports:
//   clk        - pipeline clock
//   reset      - synchronous, active-high
//   start      - E-stage instruction is MD-class, md_op valid
//   md_op      - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   rs_E/rt_E  - operands A/B (forwarded)
//   md_instr_D - D-stage instruction is MD-class (incl. mfhi/mflo)
//   busy       - operation in progress
//   md_stall_D - stall D (combinational)
//   hi/lo      - HI/LO registers
module md_unit_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_E,
  input  logic [31:0] rt_E,
  input  logic        md_instr_D,
  output logic        busy,
  output logic        md_stall_D,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [31:0]     a_q, b_q;
  logic            signed_q;
  logic            busy_q;
  logic [31:0]     hi_q, lo_q;

  // Result datapath, evaluated from the latched operands only.
  logic [63:0] a_ext, b_ext, prod;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_div, q_mag, r_mag, quot, rem;

  always_comb begin
    a_ext = {{32{signed_q & a_q[31]}}, a_q};
    b_ext = {{32{signed_q & b_q[31]}}, b_q};
    // Low 64 bits of the extended product are correct for both signednesses.
    prod  = a_ext * b_ext;

    // Sign-magnitude division gives truncation toward zero and a remainder
    // carrying the dividend's sign, and sidesteps the signed overflow case.
    a_neg = signed_q & a_q[31];
    b_neg = signed_q & b_q[31];
    a_mag = a_neg ? (32'd0 - a_q) : a_q;
    b_mag = b_neg ? (32'd0 - b_q) : b_q;
    b_div = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag = a_mag / b_div;
    r_mag = a_mag % b_div;
    quot  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem   = a_neg ? (32'd0 - r_mag) : r_mag;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      busy_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            case (md_op)
              3'd0, 3'd1: begin
                a_q      <= rs_E;
                b_q      <= rt_E;
                signed_q <= (md_op == 3'd0);
                cnt_q    <= CntW'(MULT_CYCLES);
                busy_q   <= 1'b1;
                state_q  <= StMul;
              end
              3'd2, 3'd3: begin
                a_q      <= rs_E;
                b_q      <= rt_E;
                signed_q <= (md_op == 3'd2);
                cnt_q    <= CntW'(DIV_CYCLES);
                busy_q   <= 1'b1;
                state_q  <= StDiv;
              end
              3'd4:    hi_q <= rs_E;
              3'd5:    lo_q <= rs_E;
              default: ;
            endcase
          end
        end
        StMul, StDiv: begin
          // Any start seen here is a hazard-logic bug and is dropped.
          if (cnt_q > CntW'(1)) begin
            cnt_q <= cnt_q - CntW'(1);
          end else begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= StIdle;
            if (state_q == StMul) begin
              hi_q <= prod[63:32];
              lo_q <= prod[31:0];
            end else if (b_q != 32'd0) begin
              // Divide by zero leaves HI/LO untouched.
              hi_q <= rem;
              lo_q <= quot;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy       = busy_q;
  assign hi         = hi_q;
  assign lo         = lo_q;
  // Covers the start cycle itself, before busy has risen.
  assign md_stall_D = md_instr_D & (busy_q | (start & (md_op <= 3'd3)));

endmodule
